// File: rtl/mips_pkg.sv
// mips_pkg: arbiter state encoding and port identifiers shared by the memory arbiter.
package mips_pkg;
  typedef enum logic [2:0] {IDLE, ACC_I, ACC_D, RSP_I, RSP_D} arb_state_t;
  localparam logic ARB_PORT_I = 1'b0;
  localparam logic ARB_PORT_D = 1'b1;
endpackage

// File: rtl/mem_arbiter_mux2.sv
// mux2: two-input word multiplexer, i_sel=1 selects i_b.
module mux2 #(
  parameter int WIDTH = 32
) (
  input  logic             i_sel,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);
  assign o_y = i_sel ? i_b : i_a;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-cycle memory between a fetch port and a load/store port.
// Define MEM_ARB_FIXED_PRIO_EN to make the data port win every tie instead of round-robin.
module mem_arbiter
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  output logic             i_gnt,
  output logic             i_rvalid,
  output logic [WIDTH-1:0] i_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [WIDTH-1:0] d_rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);
  arb_state_t       r_state, w_next;
  logic             r_last, w_next_last, w_pick_d;
  logic [WIDTH-1:0] r_i_rdata, r_d_rdata;
`ifdef MEM_ARB_FIXED_PRIO_EN
  assign w_pick_d = d_req;
`else
  assign w_pick_d = d_req & (~i_req | (r_last == ARB_PORT_I));
`endif
  // Arbitration happens only from IDLE or a response cycle; access cycles always advance.
  always_comb begin
    w_next      = IDLE;
    w_next_last = r_last;
    if (r_state == ACC_I) w_next = RSP_I;
    else if (r_state == ACC_D) w_next = RSP_D;
    else if (i_req | d_req) begin
      w_next      = w_pick_d ? ACC_D : ACC_I;
      w_next_last = w_pick_d ? ARB_PORT_D : ARB_PORT_I;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_last    <= ARB_PORT_D;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_last  <= w_next_last;
      if (r_state == RSP_I) r_i_rdata <= mem_rdata;
      if (r_state == RSP_D) r_d_rdata <= mem_rdata;
    end
  end
  assign i_gnt     = r_state == ACC_I;
  assign d_gnt     = r_state == ACC_D;
  assign i_rvalid  = r_state == RSP_I;
  assign d_rvalid  = r_state == RSP_D;
  assign i_rdata   = i_rvalid ? mem_rdata : r_i_rdata;
  assign d_rdata   = d_rvalid ? mem_rdata : r_d_rdata;
  assign mem_en    = i_gnt | d_gnt;
  assign mem_we    = d_gnt & d_we;
  assign mem_wdata = d_wdata;
  mux2 #(.WIDTH(WIDTH)) u_addr_mux (
    .i_sel(d_gnt),
    .i_a  (i_addr),
    .i_b  (d_addr),
    .o_y  (mem_addr)
  );
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a slot-level model.
// Honours MEM_ARB_FIXED_PRIO_EN in the tie-break expectations.
module tb_mem_arbiter;
  localparam int NONE = 0;
  localparam int PI = 1;
  localparam int PD = 2;
`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  int          n_chk = 0, n_pass = 0;
  mem_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] init_word(int i);
    return (i == 16) ? 32'h8C220004 : (32'hA5000000 ^ (i * 32'h00010203));
  endfunction
  // Environment memory: one-cycle read latency, read-before-write on stores.
  logic [31:0]  bmem [256];
  logic [255:0] bwr = '0;
  logic [31:0]  r_rd = '0;
  assign mem_rdata = r_rd;
  always @(posedge clk) begin
    if (mem_en) begin
      r_rd <= bwr[mem_addr[9:2]] ? bmem[mem_addr[9:2]] : init_word(int'(mem_addr[9:2]));
      if (mem_we) begin
        bmem[mem_addr[9:2]] <= mem_wdata;
        bwr[mem_addr[9:2]]  <= 1'b1;
      end
    end
  end
  // Reference model: which port occupies the access slot and the response slot this cycle.
  int          m_acc, m_rsp, m_last;
  logic [31:0] m_data, m_hold_i, m_hold_d;
  logic [31:0] mmem [256];
  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
  endtask
  task automatic model_reset();
    m_acc = NONE;
    m_rsp = NONE;
    m_last = PD;
    m_hold_i = '0;
    m_hold_d = '0;
  endtask
  task automatic model_adv();
    int idx;
    if (m_acc != NONE) begin
      idx = int'(m_acc == PD ? d_addr[9:2] : i_addr[9:2]);
      m_data = mmem[idx];
      if (m_acc == PD && d_we) mmem[idx] = d_wdata;
      m_rsp = m_acc;
      m_acc = NONE;
    end else begin
      if (m_rsp == PI) m_hold_i = m_data;
      if (m_rsp == PD) m_hold_d = m_data;
      m_rsp = NONE;
      if (d_req && (!i_req || FIXED || m_last == PI)) m_acc = PD;
      else if (i_req) m_acc = PI;
      if (m_acc != NONE) m_last = m_acc;
    end
  endtask
  task automatic cycle();
    model_adv();
    @(posedge clk);
    #1;
    check("i_gnt", i_gnt, m_acc == PI);
    check("d_gnt", d_gnt, m_acc == PD);
    check("mem_en", mem_en, m_acc != NONE);
    check("mem_we", mem_we, m_acc == PD && d_we);
    check("mem_addr", mem_addr, m_acc == PD ? d_addr : i_addr);
    check("mem_wdata", mem_wdata, d_wdata);
    check("i_rvalid", i_rvalid, m_rsp == PI);
    check("d_rvalid", d_rvalid, m_rsp == PD);
    check("i_rdata", i_rdata, m_rsp == PI ? m_data : m_hold_i);
    check("d_rdata", d_rdata, m_rsp == PD ? m_data : m_hold_d);
    if (i_gnt) i_req = 1'b0;
    if (d_gnt) d_req = 1'b0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    logic [7:0] seq;
    int loads;
    for (int i = 0; i < 256; i++) mmem[i] = init_word(i);
    model_reset();
    #1;
    check("rst_i_gnt", i_gnt, 1'b0);
    check("rst_d_gnt", d_gnt, 1'b0);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_rvalid", {i_rvalid, d_rvalid}, 2'b00);
    check("rst_rdata", i_rdata | d_rdata, 32'h0);
    do_reset();
    i_req = 1'b1;
    i_addr = 32'h40;
    cycle();
    check("fetch_gnt", i_gnt, 1'b1);
    cycle();
    check("fetch_rvalid", i_rvalid, 1'b1);
    check("fetch_data", i_rdata, 32'h8C220004);
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h100;
    d_wdata = 32'hDEADBEEF;
    cycle();
    check("store_en_we", {mem_en, mem_we}, 2'b11);
    check("store_addr", mem_addr, 32'h100);
    check("store_wdata", mem_wdata, 32'hDEADBEEF);
    cycle();
    check("store_ack", d_rvalid, 1'b1);
    d_we = 1'b0;
    repeat (10) cycle();
    do_reset();
    i_req = 1'b1;
    d_req = 1'b1;
    i_addr = 32'h80;
    d_addr = 32'h100;
    seq = '0;
    repeat (8) begin
      cycle();
      if (i_gnt) seq = {seq[5:0], 2'b01};
      if (d_gnt) seq = {seq[5:0], 2'b10};
      i_req = 1'b1;
      d_req = 1'b1;
    end
    check("tie_order", seq, FIXED ? 8'hAA : 8'h66);
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (3) cycle();
    d_req = 1'b1;
    d_addr = 32'h20;
    loads = 0;
    seq = '0;
    repeat (4) begin
      cycle();
      seq = {seq[5:0], d_gnt, d_rvalid};
      if (d_gnt) loads++;
      if (d_gnt && loads < 2) d_req = 1'b1;
    end
    check("b2b_loads", seq, 8'h99);
    d_req = 1'b1;
    d_addr = 32'h44;
    cycle();
    check("abort_in_acc", d_gnt, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_strobes", {d_gnt, i_gnt, mem_en, mem_we, d_rvalid, i_rvalid}, 6'b0);
    check("abort_rdata", i_rdata | d_rdata, 32'h0);
    d_req = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle();
    for (int k = 0; k < 400; k++) begin
      if (!i_req && !i_gnt && $urandom_range(0, 2) == 0) begin
        i_req = 1'b1;
        i_addr = 32'($urandom_range(0, 255)) << 2;
      end
      if (!d_req && !d_gnt && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1;
        d_we = $urandom_range(0, 1) == 1;
        d_addr = 32'($urandom_range(0, 255)) << 2;
        d_wdata = $urandom;
      end
      cycle();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
